// File: rtl/jk_up_down_counter_n.sv
`default_nettype none
//==============================================================================
// Module   : jk_up_down_counter_n
// Function : Modulo-MODULUS up/down counter with IDLE/RUN/HALT control,
//            wrap or one-shot terminal behaviour and synchronous load.
// Options  : define JK_COUNTER_CAPTURE_EN to add the capture/capturedValue port.
// Revision : 1.0 - initial release
//==============================================================================
module jk_up_down_counter_n #(
   parameter int WIDTH   = 5,
   parameter int MODULUS = 32
) (
   input  logic             clockPulse,
   input  logic             reset,
   input  logic             enable,
   input  logic             upDown,
   input  logic             oneShot,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
`ifdef JK_COUNTER_CAPTURE_EN
   input  logic             capture,
   output logic [WIDTH-1:0] capturedValue,
`endif
   output logic [WIDTH-1:0] Result,
   output logic             terminalCount,
   output logic             wrapPulse,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0]       c_stIdle = 2'd0;
   localparam logic [1:0]       c_stRun  = 2'd1;
   localparam logic [1:0]       c_stHalt = 2'd2;
   localparam logic [WIDTH-1:0] c_maxVal = WIDTH'(MODULUS - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_nextResult;
   logic [WIDTH-1:0] w_terminal;
   logic [WIDTH-1:0] w_clampedLoad;
   logic             r_wrapPulse;
   logic             r_busy;
   logic             r_done;
   logic             w_wrap;
   logic             w_busyNext;
   logic             w_doneNext;
   logic             w_atTerminal;
   logic             w_countStep;

   assign w_terminal    = upDown ? c_maxVal : '0;
   assign w_atTerminal  = (r_result == w_terminal);
   // A load pre-empts the count step but not the start-driven state change.
   assign w_countStep   = !load && enable && (r_state == c_stRun);
   assign w_clampedLoad = ({{(32-WIDTH){1'b0}}, loadValue} >= 32'(MODULUS)) ? c_maxVal : loadValue;

   always_ff @(posedge clockPulse) begin
      if (reset) begin
         r_state     <= c_stIdle;
         r_result    <= '0;
         r_wrapPulse <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_result    <= w_nextResult;
         r_wrapPulse <= w_wrap;
         r_busy      <= w_busyNext;
         r_done      <= w_doneNext;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_stIdle: if (start) w_nextState = c_stRun;
         c_stRun:  if (w_countStep && w_atTerminal && oneShot) w_nextState = c_stHalt;
         c_stHalt: if (start) w_nextState = c_stRun;
         default:  w_nextState = c_stIdle;
      endcase
   end

   always_comb begin
      w_busyNext = (w_nextState == c_stRun);
      w_doneNext = (w_nextState == c_stHalt);
   end

   always_comb begin
      w_nextResult = r_result;
      w_wrap       = 1'b0;
      if (load) begin
         w_nextResult = w_clampedLoad;
      end else if ((r_state == c_stHalt) && start) begin
         w_nextResult = upDown ? '0 : c_maxVal;
      end else if (w_countStep) begin
         if (w_atTerminal) begin
            if (!oneShot) begin
               w_nextResult = upDown ? '0 : c_maxVal;
               w_wrap       = 1'b1;
            end
         end else if (upDown) begin
            w_nextResult = r_result + WIDTH'(1);
         end else begin
            w_nextResult = r_result - WIDTH'(1);
         end
      end
   end

`ifdef JK_COUNTER_CAPTURE_EN
   logic [WIDTH-1:0] r_captured;

   always_ff @(posedge clockPulse) begin
      if (reset) begin
         r_captured <= '0;
      end else if (capture) begin
         r_captured <= r_result;
      end
   end

   assign capturedValue = r_captured;
`endif

   assign Result        = r_result;
   assign terminalCount = w_atTerminal;
   assign wrapPulse     = r_wrapPulse;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jk_up_down_counter_n.sv
`default_nettype none
//==============================================================================
// Module   : tb_jk_up_down_counter_n
// Function : Scoreboard bench for jk_up_down_counter_n (default and MODULUS=10).
// Revision : 1.0 - initial release
//==============================================================================
module tb_jk_up_down_counter_n;

   localparam int W  = 5;
   localparam int MA = 32;
   localparam int MB = 10;

   typedef struct {
      int res;
      bit tc;
      bit wp;
      bit busy;
      bit done;
      int cap;
   } exp_t;

   logic         clockPulse = 1'b0;
   logic         reset = 1'b1, enable = 1'b0, upDown = 1'b1, oneShot = 1'b0;
   logic         start = 1'b0, load = 1'b0, capture = 1'b0;
   logic [W-1:0] loadValue = '0;
   logic [W-1:0] resA, resB, capA, capB;
   logic         tcA, tcB, wpA, wpB, busyA, busyB, doneA, doneB;

   exp_t qA[$];
   exp_t qB[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference state: st 0=idle 1=run 2=halt
   int   mRes[2];
   int   mSt[2];
   int   mCap[2];

   always #5 clockPulse = ~clockPulse;

   jk_up_down_counter_n #(.WIDTH(W), .MODULUS(MA)) dutA (
      .clockPulse(clockPulse), .reset(reset), .enable(enable), .upDown(upDown),
      .oneShot(oneShot), .start(start), .load(load), .loadValue(loadValue),
`ifdef JK_COUNTER_CAPTURE_EN
      .capture(capture), .capturedValue(capA),
`endif
      .Result(resA), .terminalCount(tcA), .wrapPulse(wpA), .busy(busyA), .done(doneA)
   );

   jk_up_down_counter_n #(.WIDTH(W), .MODULUS(MB)) dutB (
      .clockPulse(clockPulse), .reset(reset), .enable(enable), .upDown(upDown),
      .oneShot(oneShot), .start(start), .load(load), .loadValue(loadValue),
`ifdef JK_COUNTER_CAPTURE_EN
      .capture(capture), .capturedValue(capB),
`endif
      .Result(resB), .terminalCount(tcB), .wrapPulse(wpB), .busy(busyB), .done(doneB)
   );

`ifndef JK_COUNTER_CAPTURE_EN
   assign capA = '0;
   assign capB = '0;
`endif

   function automatic exp_t modelStep(input int k, input bit r, input bit en, input bit up,
                                      input bit os, input bit st, input bit ld, input int lv,
                                      input bit cp);
      int   m = (k == 0) ? MA : MB;
      int   top;
      bit   startGo;
      exp_t e;
      e.wp = 1'b0;
      if (r) begin
         mRes[k] = 0;
         mSt[k]  = 0;
         mCap[k] = 0;
      end else begin
         top     = up ? m - 1 : 0;
         startGo = st && (mSt[k] != 1);
         if (cp) mCap[k] = mRes[k];
         if (ld) begin
            mRes[k] = (lv > m - 1) ? m - 1 : lv;
            if (startGo) mSt[k] = 1;
         end else if (startGo) begin
            if (mSt[k] == 2) mRes[k] = up ? 0 : m - 1;
            mSt[k] = 1;
         end else if (mSt[k] == 1 && en) begin
            if (mRes[k] == top && os) begin
               mSt[k] = 2;
            end else begin
               e.wp    = (mRes[k] == top);
               mRes[k] = up ? (mRes[k] + 1) % m : (mRes[k] + m - 1) % m;
            end
         end
      end
      e.res  = mRes[k];
      e.tc   = (mRes[k] == (up ? m - 1 : 0));
      e.busy = (mSt[k] == 1);
      e.done = (mSt[k] == 2);
      e.cap  = mCap[k];
      return e;
   endfunction

   task automatic drive(input bit r, input bit en, input bit up, input bit os,
                        input bit st, input bit ld, input int lv, input bit cp);
      @(negedge clockPulse);
      reset = r; enable = en; upDown = up; oneShot = os;
      start = st; load = ld; loadValue = W'(lv); capture = cp;
      qA.push_back(modelStep(0, r, en, up, os, st, ld, lv, cp));
      qB.push_back(modelStep(1, r, en, up, os, st, ld, lv, cp));
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every edge yields one response per DUT
   always @(posedge clockPulse) begin
      exp_t e;
      #1;
      if (qA.size() > 0) begin
         e = qA.pop_front();
         check("A.Result", int'(resA), e.res);
         check("A.terminalCount", int'(tcA), int'(e.tc));
         check("A.wrapPulse", int'(wpA), int'(e.wp));
         check("A.busy", int'(busyA), int'(e.busy));
         check("A.done", int'(doneA), int'(e.done));
`ifdef JK_COUNTER_CAPTURE_EN
         check("A.capturedValue", int'(capA), e.cap);
`endif
      end
      if (qB.size() > 0) begin
         e = qB.pop_front();
         check("B.Result", int'(resB), e.res);
         check("B.terminalCount", int'(tcB), int'(e.tc));
         check("B.wrapPulse", int'(wpB), int'(e.wp));
         check("B.busy", int'(busyB), int'(e.busy));
         check("B.done", int'(doneB), int'(e.done));
`ifdef JK_COUNTER_CAPTURE_EN
         check("B.capturedValue", int'(capB), e.cap);
`endif
      end
   end

   initial begin
      bit ud = 1'b1;
      bit os = 1'b0;
      // Reset and wrap-mode count-up over the full default range
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 34; i++) drive(0, 1, 1, 0, 0, 0, 0, 0);
      // Down count from a loaded value with simultaneous start
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 3, 0);
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
      // One-shot halt, enable ignored while halted, restart
      drive(1, 0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 13; i++) drive(0, 1, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 1, 1, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 0, 0, 0);
      // Load clamp, then load together with start from idle
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 1, 15, 0);
      drive(0, 0, 1, 0, 0, 1, 31, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 1, 6, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      // Reset beats load mid-run
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) drive(0, 1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 1, 4, 0);
      drive(0, 1, 1, 0, 1, 0, 0, 0);
      // Capture while counting
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 1);
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 10) ud = ~ud;
         if ($urandom_range(0, 99) < 5) os = ~os;
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, ud, os,
               $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5,
               int'($urandom_range(0, 31)), $urandom_range(0, 99) < 20);
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clockPulse);
      check("scoreboard.drainA", qA.size(), 0);
      check("scoreboard.drainB", qB.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
